rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYC, default 1024, consecutive synchronized-lock cycles required before the first release (min 2).
REQ-002 SHALL have parameter STAGE_GAP_CYC, default 16, cycles between successive domain releases (min 1).
REQ-003 SHALL have parameter MIN_ASSERT_CYC, default 32, minimum cycles all domain resets stay asserted after a fault event (min 1).
REQ-004 clk_i  input  1  system clock (PLL output domain); single clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is internally synchronized by 2 flops.
REQ-006 pll_locked_i  input  1  PLL lock status, asynchronous; synchronized by 2 flops (locked_s).
REQ-007 wdt_reset_i  input  1  watchdog reset request, synchronous level.
REQ-008 sw_reset_i  input  1  software reset request, synchronous one-cycle pulse.
REQ-009 prog_mode_i  input  1  programming mode, synchronous level; holds the core in reset.
REQ-010 periph_rst_no  output  1  peripheral-domain reset, active low, registered.
REQ-011 mem_rst_no  output  1  memory-domain reset, active low, registered.
REQ-012 core_rst_no  output  1  CPU-core reset, active low, registered.
REQ-013 rst_done_o  output  1  high while state is RUN.
REQ-014 rst_cause_o  output  3  last reset cause: 001 POR, 010 PLL loss, 011 WDT, 100 SW.

Function
REQ-015 States SHALL be WAIT_LOCK, REL_PERIPH, REL_MEM, RUN, HOLD; one cycle-counter, width $clog2(max(param)+1), shared by all states.
REQ-016 WAIT_LOCK: counter increments each cycle locked_s=1, clears to 0 on any cycle locked_s=0; when counter reaches LOCK_STABLE_CYC-1 with locked_s=1 -> REL_PERIPH, periph_rst_no=1 on that edge.
REQ-017 periph_rst_no SHALL rise exactly LOCK_STABLE_CYC cycles after the first cycle of an unbroken locked_s=1 run.
REQ-018 REL_PERIPH: after STAGE_GAP_CYC cycles -> REL_MEM, mem_rst_no=1 on that edge.
REQ-019 REL_MEM: after STAGE_GAP_CYC cycles -> RUN, core_rst_no=1 on that edge unless prog_mode_i=1.
REQ-020 RUN: core_rst_no SHALL be registered !prog_mode_i (1-cycle latency); prog_mode_i toggling SHALL NOT affect periph/mem resets, rst_done_o or state.
REQ-021 Fault events: locked_s=0 (in REL_PERIPH, REL_MEM, RUN), wdt_reset_i=1, sw_reset_i=1 (in any state except HOLD and WAIT_LOCK) -> HOLD; all three rst_no=0 and rst_done_o=0 on the next edge (1-cycle latency).
REQ-022 Simultaneous events SHALL record one cause with priority PLL loss > WDT > SW; rst_cause_o updates on the HOLD-entry edge.
REQ-023 HOLD: all resets asserted for exactly MIN_ASSERT_CYC cycles, then -> WAIT_LOCK with counter cleared; events during HOLD ignored, cause unchanged.
REQ-024 WAIT_LOCK: wdt_reset_i/sw_reset_i ignored (resets already asserted); cause unchanged.
REQ-025 wdt_reset_i held high SHALL re-enter HOLD from the first cycle after HOLD exits in which the state is REL_PERIPH or later; it SHALL NOT block lock counting.
REQ-026 Counter SHALL never wrap; it saturates at its terminal value only while the transition is taken.

Reset
REQ-027 rst_ni=0 SHALL asynchronously force periph_rst_no=0, mem_rst_no=0, core_rst_no=0, rst_done_o=0, rst_cause_o=001, state WAIT_LOCK, counter 0, sync flops 0.
REQ-028 rst_ni assertion mid-sequence (any state) SHALL restart from REQ-027; after deassertion, 2 sync cycles elapse before state logic advances.

Verification (LOCK_STABLE_CYC=8, STAGE_GAP_CYC=4, MIN_ASSERT_CYC=6)
REQ-029 POR, pll_locked_i=1 from reset release -> periph_rst_no rises 8 cycles after locked_s first high, mem 4 later, core 4 later, rst_done_o=1, cause 001.
REQ-030 pll_locked_i glitches low 1 cycle at count 5 in WAIT_LOCK -> counter clears; periph release 8 cycles after locked_s returns high.
REQ-031 In RUN, wdt_reset_i and sw_reset_i high in same cycle -> all resets 0 next cycle, cause 011, held 6 cycles, then full resequence.
REQ-032 In RUN, pll_locked_i falls while sw_reset_i pulses -> cause 010; sequencer stays in WAIT_LOCK until 8 stable lock cycles.
REQ-033 prog_mode_i=1 through REL_MEM->RUN -> core_rst_no stays 0, rst_done_o=1; prog_mode_i falls -> core_rst_no=1 one cycle later.
REQ-034 rst_ni pulsed low during REL_MEM -> all outputs reset immediately (asynchronous), cause 001, full resequence.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for a stable PLL lock, then releases the peripheral,
// memory and core reset domains in order. Any fault (PLL loss, watchdog or
// software request) asserts all domain resets for a minimum hold time and
// restarts the sequence from lock qualification.
module rst_sequencer #(
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int STAGE_GAP_CYC   = 16,
  parameter int MIN_ASSERT_CYC  = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       wdt_reset_i,
  input  logic       sw_reset_i,
  input  logic       prog_mode_i,
  output logic       periph_rst_no,
  output logic       mem_rst_no,
  output logic       core_rst_no,
  output logic       rst_done_o,
  output logic [2:0] rst_cause_o
);

  localparam int MAX_AB = (LOCK_STABLE_CYC > STAGE_GAP_CYC) ? LOCK_STABLE_CYC : STAGE_GAP_CYC;
  localparam int MAX_P  = (MAX_AB > MIN_ASSERT_CYC) ? MAX_AB : MIN_ASSERT_CYC;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] LOCK_TERM = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_TERM  = CW'(STAGE_GAP_CYC - 1);
  localparam logic [CW-1:0] HOLD_TERM = CW'(MIN_ASSERT_CYC - 1);

  localparam logic [2:0] S_WAIT_LOCK  = 3'd0;
  localparam logic [2:0] S_REL_PERIPH = 3'd1;
  localparam logic [2:0] S_REL_MEM    = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_HOLD       = 3'd4;

  localparam logic [2:0] CAUSE_POR = 3'b001;
  localparam logic [2:0] CAUSE_PLL = 3'b010;
  localparam logic [2:0] CAUSE_WDT = 3'b011;
  localparam logic [2:0] CAUSE_SW  = 3'b100;

  logic [1:0]    rst_sync;
  logic [1:0]    lock_sync;
  logic          run_en;
  logic          locked_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          fault;
  logic [2:0]    fault_cause;

  // Reset deassertion synchronizer; state logic holds until it has filled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  // PLL lock synchronizer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lock_sync <= 2'b00;
    else         lock_sync <= {lock_sync[0], pll_locked_i};
  end

  assign run_en   = rst_sync[1];
  assign locked_s = lock_sync[1];

  // Fault detection with cause priority PLL loss > WDT > SW. Only live once
  // at least one domain has been released; HOLD and WAIT_LOCK ignore requests.
  always_comb begin
    fault       = 1'b0;
    fault_cause = CAUSE_SW;
    if (state == S_REL_PERIPH || state == S_REL_MEM || state == S_RUN) begin
      if (!locked_s) begin
        fault       = 1'b1;
        fault_cause = CAUSE_PLL;
      end else if (wdt_reset_i) begin
        fault       = 1'b1;
        fault_cause = CAUSE_WDT;
      end else if (sw_reset_i) begin
        fault       = 1'b1;
        fault_cause = CAUSE_SW;
      end
    end
  end

  // Sequencer FSM; one shared counter, cleared on every state transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_WAIT_LOCK;
      cnt           <= '0;
      periph_rst_no <= 1'b0;
      mem_rst_no    <= 1'b0;
      core_rst_no   <= 1'b0;
      rst_cause_o   <= CAUSE_POR;
    end else if (run_en) begin
      if (fault) begin
        state         <= S_HOLD;
        cnt           <= '0;
        periph_rst_no <= 1'b0;
        mem_rst_no    <= 1'b0;
        core_rst_no   <= 1'b0;
        rst_cause_o   <= fault_cause;
      end else begin
        case (state)
          S_WAIT_LOCK: begin
            if (!locked_s) begin
              cnt <= '0;
            end else if (cnt == LOCK_TERM) begin
              state         <= S_REL_PERIPH;
              cnt           <= '0;
              periph_rst_no <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REL_PERIPH: begin
            if (cnt == GAP_TERM) begin
              state      <= S_REL_MEM;
              cnt        <= '0;
              mem_rst_no <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_REL_MEM: begin
            if (cnt == GAP_TERM) begin
              state       <= S_RUN;
              cnt         <= '0;
              core_rst_no <= !prog_mode_i;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
            core_rst_no <= !prog_mode_i;
          end
          S_HOLD: begin
            if (cnt == HOLD_TERM) begin
              state <= S_WAIT_LOCK;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state         <= S_WAIT_LOCK;
            cnt           <= '0;
            periph_rst_no <= 1'b0;
            mem_rst_no    <= 1'b0;
            core_rst_no   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rst_done_o = (state == S_RUN);

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with LOCK=8, GAP=4, HOLD=6.
module tb_rst_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       pll_locked_i;
  logic       wdt_reset_i;
  logic       sw_reset_i;
  logic       prog_mode_i;
  logic       periph_rst_no;
  logic       mem_rst_no;
  logic       core_rst_no;
  logic       rst_done_o;
  logic [2:0] rst_cause_o;

  int n_chk  = 0;
  int n_fail = 0;

  rst_sequencer #(
    .LOCK_STABLE_CYC(8),
    .STAGE_GAP_CYC  (4),
    .MIN_ASSERT_CYC (6)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pll_locked_i (pll_locked_i),
    .wdt_reset_i  (wdt_reset_i),
    .sw_reset_i   (sw_reset_i),
    .prog_mode_i  (prog_mode_i),
    .periph_rst_no(periph_rst_no),
    .mem_rst_no   (mem_rst_no),
    .core_rst_no  (core_rst_no),
    .rst_done_o   (rst_done_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    pll_locked_i = 1'b1;
    wdt_reset_i  = 1'b0;
    sw_reset_i   = 1'b0;
    prog_mode_i  = 1'b0;

    // Reset state
    tick(3);
    chk("rst_periph", periph_rst_no, 0);
    chk("rst_mem",    mem_rst_no,    0);
    chk("rst_core",   core_rst_no,   0);
    chk("rst_done",   rst_done_o,    0);
    chk("rst_cause",  rst_cause_o,   3'b001);

    // POR with lock present: periph at edge 10, mem 14, core 18
    rst_ni = 1'b1;
    tick(9);  chk("por_periph_early", periph_rst_no, 0);
    tick(1);  chk("por_periph_rise",  periph_rst_no, 1);
              chk("por_mem_low",      mem_rst_no,    0);
    tick(3);  chk("por_mem_early",    mem_rst_no,    0);
    tick(1);  chk("por_mem_rise",     mem_rst_no,    1);
    tick(3);  chk("por_core_early",   core_rst_no,   0);
              chk("por_done_early",   rst_done_o,    0);
    tick(1);  chk("por_core_rise",    core_rst_no,   1);
              chk("por_done",         rst_done_o,    1);
              chk("por_cause",        rst_cause_o,   3'b001);

    // Lock glitch while counting: counter restarts
    rst_ni = 1'b0; pll_locked_i = 1'b0;
    tick(2);  chk("glitch_rst_periph", periph_rst_no, 0);
    rst_ni = 1'b1;
    tick(4);  pll_locked_i = 1'b1;
    tick(5);  pll_locked_i = 1'b0;
    tick(1);  pll_locked_i = 1'b1;
    tick(4);  chk("glitch_no_early_release", periph_rst_no, 0);
    tick(5);  chk("glitch_periph_early",     periph_rst_no, 0);
    tick(1);  chk("glitch_periph_rise",      periph_rst_no, 1);
    tick(4);  chk("glitch_mem_rise",         mem_rst_no,    1);
    tick(4);  chk("glitch_core_rise",        core_rst_no,   1);
              chk("glitch_done",             rst_done_o,    1);

    // WDT + SW together in RUN: cause WDT, 6-cycle hold, resequence
    wdt_reset_i = 1'b1; sw_reset_i = 1'b1;
    tick(1);  chk("wdsw_periph", periph_rst_no, 0);
              chk("wdsw_mem",    mem_rst_no,    0);
              chk("wdsw_core",   core_rst_no,   0);
              chk("wdsw_done",   rst_done_o,    0);
              chk("wdsw_cause",  rst_cause_o,   3'b011);
    wdt_reset_i = 1'b0; sw_reset_i = 1'b0;
    tick(13); chk("wdsw_periph_early", periph_rst_no, 0);
    tick(1);  chk("wdsw_periph_rise",  periph_rst_no, 1);
    tick(8);  chk("wdsw_core_rise",    core_rst_no,   1);
              chk("wdsw_done_again",   rst_done_o,    1);
              chk("wdsw_cause_kept",   rst_cause_o,   3'b011);

    // PLL loss coincident with SW pulse: cause PLL, wait for relock
    pll_locked_i = 1'b0;
    tick(2);  sw_reset_i = 1'b1;
    tick(1);  sw_reset_i = 1'b0;
              chk("pll_core",  core_rst_no, 0);
              chk("pll_done",  rst_done_o,  0);
              chk("pll_cause", rst_cause_o, 3'b010);
    tick(20); chk("pll_wait_periph", periph_rst_no, 0);
    pll_locked_i = 1'b1;
    tick(9);  chk("pll_periph_early", periph_rst_no, 0);
    tick(1);  chk("pll_periph_rise",  periph_rst_no, 1);

    // Programming mode through REL_MEM->RUN keeps core in reset
    prog_mode_i = 1'b1;
    tick(4);  chk("prog_mem_rise", mem_rst_no,  1);
    tick(4);  chk("prog_done",     rst_done_o,  1);
              chk("prog_core_held", core_rst_no, 0);
    tick(2);  prog_mode_i = 1'b0;
              chk("prog_core_lat", core_rst_no, 0);
    tick(1);  chk("prog_core_rel", core_rst_no, 1);
    prog_mode_i = 1'b1;
    tick(1);  chk("prog_core_reassert", core_rst_no,   0);
              chk("prog_done_kept",     rst_done_o,    1);
              chk("prog_periph_kept",   periph_rst_no, 1);
    prog_mode_i = 1'b0;
    tick(1);  chk("prog_core_rel2", core_rst_no, 1);

    // WDT held high: re-enters HOLD on first cycle in REL_PERIPH
    wdt_reset_i = 1'b1;
    tick(1);  chk("wdth_periph", periph_rst_no, 0);
              chk("wdth_cause",  rst_cause_o,   3'b011);
    tick(14); chk("wdth_periph_rel", periph_rst_no, 1);
    tick(1);  chk("wdth_reenter",    periph_rst_no, 0);
              chk("wdth_done",       rst_done_o,    0);
    wdt_reset_i = 1'b0;
    tick(14); chk("wdth_periph_rel2", periph_rst_no, 1);
    tick(4);  chk("wdth_mem_rise",    mem_rst_no,    1);
              chk("wdth_core_low",    core_rst_no,   0);

    // Async reset mid-sequence (REL_MEM)
    tick(1);
    #3 rst_ni = 1'b0;
    #1;
    chk("async_periph", periph_rst_no, 0);
    chk("async_mem",    mem_rst_no,    0);
    chk("async_cause",  rst_cause_o,   3'b001);
    @(posedge clk_i); #1;
    tick(1);
    rst_ni = 1'b1;
    tick(9);  chk("async_periph_early", periph_rst_no, 0);
    tick(1);  chk("async_periph_rise",  periph_rst_no, 1);
    tick(8);  chk("async_core_rise",    core_rst_no,   1);
              chk("async_done",         rst_done_o,    1);
              chk("async_cause_kept",   rst_cause_o,   3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
